// File: rtl/adder_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined N-operand adder/accumulator.
package adder_pipe_pkg;

  typedef struct packed {
    logic acc_en;
    logic acc_first;
  } side_t;

  localparam int SIDE_W = $bits(side_t);

  function automatic int sum_width(input int w, input int n);
    return w + $clog2(n);
  endfunction

  // Legal configurations: LAT of 1 or 2, 2..16 operands, accumulator at least as wide as the sum.
  function automatic bit cfg_legal(input int lat, input int n, input int w, input int aw);
    return ((lat == 1) || (lat == 2)) && (n >= 2) && (n <= 16) && (aw >= sum_width(w, n));
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic valid/ready pipeline register: loads whenever it is empty or its beat leaves this cycle.
module pipe_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data
);

  logic          valid_r;
  logic [DW-1:0] data_r;
  logic          load_s;

  assign load_s   = !valid_r || dn_ready;
  assign up_ready = load_s;
  assign dn_valid = valid_r;
  assign dn_data  = data_r;

  // Occupancy and payload; the payload only moves when a real beat enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {DW{1'b0}};
    end else begin
      if (load_s) valid_r <= up_valid;
      else        valid_r <= valid_r;
      if (load_s && up_valid) data_r <= up_data;
      else                    data_r <= data_r;
    end
  end

endmodule

// File: rtl/adder_pipe_acc.sv
// N-operand adder with carry-in, 1- or 2-cycle valid/ready pipeline and a saturating accumulator.
module adder_pipe_acc
  import adder_pipe_pkg::*;
#(
  parameter int W   = 8,
  parameter int N   = 4,
  parameter int LAT = 1,
  parameter int AW  = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*W:0]           ins,
  input  logic                   in_acc_en,
  input  logic                   in_acc_first,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W+$clog2(N)-1:0] sm,
  output logic                   sm_zero,
  output logic [AW-1:0]          acc,
  output logic                   acc_sat
);

  localparam int SW     = sum_width(W, N);
  localparam int NP     = (N + 1) / 2;
  localparam int PW     = W + 1;
  localparam int OPW    = 2 * NP * W;
  localparam int AW1    = AW + 1;
  localparam bit CFG_OK = cfg_legal(LAT, N, W, AW);

  if (!CFG_OK) begin : g_cfg_check
    $error("adder_pipe_acc: LAT must be 1 or 2, N in 2..16, AW >= W+clog2(N)");
  end

  logic [OPW-1:0] opnd_s;
  logic [W-1:0]   ops_s [2*NP];
  logic           cin_s;
  side_t          side_s;
  logic           live_r;
  logic           st1_ready_s;
  logic           fin_valid_s;
  logic           fin_ready_s;
  logic           fin_take_s;
  logic [SW-1:0]  fin_sum_s;
  side_t          fin_side_s;
  logic [SW:0]    out_s;
  logic [AW-1:0]  acc_r;
  logic           sat_r;
  logic [AW:0]    acc_sum_s;
  logic [AW-1:0]  acc_nxt_s;
  logic           sat_nxt_s;

  // Operands are padded to an even count with zeros so the pairwise tree needs no odd case.
  assign opnd_s = OPW'(ins[N*W-1:0]);
  assign cin_s  = ins[N*W];
  assign side_s = {in_acc_en, in_acc_first};

  // Unpack the operand bus into an array of W-bit operands.
  always_comb begin
    for (int k = 0; k < 2*NP; k++) begin
      ops_s[k] = opnd_s[k*W +: W];
    end
  end

  if (LAT == 1) begin : g_lat1
    logic [SW-1:0] sum_s;

    // Full N-operand sum in one cycle.
    always_comb begin
      sum_s = SW'(cin_s);
      for (int k = 0; k < 2*NP; k++) begin
        sum_s = sum_s + SW'(ops_s[k]);
      end
    end

    assign fin_valid_s = in_valid && live_r;
    assign st1_ready_s = fin_ready_s;
    assign fin_sum_s   = sum_s;
    assign fin_side_s  = side_s;
  end else begin : g_lat2
    localparam int S1W = NP*PW + 1 + SIDE_W;
    logic [S1W-1:0] s1_in_s;
    logic [S1W-1:0] s1_out_s;
    logic           s1_valid_s;
    logic [SW-1:0]  sum_s;

    // Stage-1 payload: pairwise partial sums, carry-in and sideband.
    always_comb begin
      s1_in_s = {S1W{1'b0}};
      for (int k = 0; k < NP; k++) begin
        s1_in_s[k*PW +: PW] = PW'(ops_s[2*k]) + PW'(ops_s[2*k+1]);
      end
      s1_in_s[NP*PW]             = cin_s;
      s1_in_s[S1W-1 -: SIDE_W]   = side_s;
    end

    pipe_reg #(.DW(S1W)) u_stage1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (in_valid && live_r),
      .up_ready (st1_ready_s),
      .up_data  (s1_in_s),
      .dn_valid (s1_valid_s),
      .dn_ready (fin_ready_s),
      .dn_data  (s1_out_s)
    );

    // Stage-2 reduction of the registered partials.
    always_comb begin
      sum_s = SW'(s1_out_s[NP*PW]);
      for (int k = 0; k < NP; k++) begin
        sum_s = sum_s + SW'(s1_out_s[k*PW +: PW]);
      end
    end

    assign fin_valid_s = s1_valid_s;
    assign fin_sum_s   = sum_s;
    assign fin_side_s  = side_t'(s1_out_s[S1W-1 -: SIDE_W]);
  end

  pipe_reg #(.DW(SW+1)) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (fin_valid_s),
    .up_ready (fin_ready_s),
    .up_data  ({fin_sum_s == {SW{1'b0}}, fin_sum_s}),
    .dn_valid (out_valid),
    .dn_ready (out_ready),
    .dn_data  (out_s)
  );

  assign sm         = out_s[SW-1:0];
  assign sm_zero    = out_s[SW];
  assign in_ready   = live_r && st1_ready_s;
  assign fin_take_s = fin_valid_s && fin_ready_s;
  assign acc        = acc_r;
  assign acc_sat    = sat_r;

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_r <= 1'b0;
    else        live_r <= 1'b1;
  end

  // Accumulator next state for the beat entering the output register; saturation is sticky.
  always_comb begin
    acc_sum_s = {1'b0, acc_r} + AW1'(fin_sum_s);
    acc_nxt_s = acc_r;
    sat_nxt_s = sat_r;
    if (fin_side_s.acc_en) begin
      if (fin_side_s.acc_first) begin
        acc_nxt_s = AW'(fin_sum_s);
        sat_nxt_s = 1'b0;
      end else if (acc_sum_s[AW]) begin
        acc_nxt_s = {AW{1'b1}};
        sat_nxt_s = 1'b1;
      end else begin
        acc_nxt_s = acc_sum_s[AW-1:0];
        sat_nxt_s = sat_r;
      end
    end else begin
      acc_nxt_s = acc_r;
      sat_nxt_s = sat_r;
    end
  end

  // Accumulator state advances together with the output register, so acc includes the shown beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {AW{1'b0}};
      sat_r <= 1'b0;
    end else if (fin_take_s) begin
      acc_r <= acc_nxt_s;
      sat_r <= sat_nxt_s;
    end else begin
      acc_r <= acc_r;
      sat_r <= sat_r;
    end
  end

endmodule

// File: tb/tb_adder_pipe_acc.sv
// Bench: three configurations driven with the same beat streams, checked against a queue-based model.
module tb_adder_pipe_acc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]  iv, ir, ov, ordy, smz, sat, aen, afst;
  logic [32:0] ins_d [3];
  logic [11:0] acc0, acc1, acc2;
  logic [9:0]  sm0, sm1;
  logic [6:0]  sm2;

  adder_pipe_acc #(.W(8), .N(4), .LAT(1), .AW(12)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .ins(ins_d[0]),
    .in_acc_en(aen[0]), .in_acc_first(afst[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .sm(sm0), .sm_zero(smz[0]), .acc(acc0), .acc_sat(sat[0]));
  adder_pipe_acc #(.W(8), .N(4), .LAT(2), .AW(12)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .ins(ins_d[1]),
    .in_acc_en(aen[1]), .in_acc_first(afst[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .sm(sm1), .sm_zero(smz[1]), .acc(acc1), .acc_sat(sat[1]));
  adder_pipe_acc #(.W(4), .N(8), .LAT(2), .AW(12)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .ins(ins_d[2]),
    .in_acc_en(aen[2]), .in_acc_first(afst[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .sm(sm2), .sm_zero(smz[2]), .acc(acc2), .acc_sat(sat[2]));

  int nvec, nerr, cyc;
  bit live;
  // stimulus list shared by all lanes; each lane walks it at its own pace
  logic [32:0] b_ins [64];
  bit          b_en [64];
  bit          b_first [64];
  int          nb;
  int          ptr [3];
  // expected-output queues (circular) and accumulator model per lane
  int e_sm [3][64];
  int e_acc [3][64];
  bit e_sat [3][64];
  int e_t [3][64];
  int hd [3];
  int tl [3];
  int macc [3];
  bit msat [3];

  function automatic logic [31:0] obs_sm(input int i);
    case (i)
      0:       return 32'(sm0);
      1:       return 32'(sm1);
      default: return 32'(sm2);
    endcase
  endfunction

  function automatic logic [31:0] obs_acc(input int i);
    case (i)
      0:       return 32'(acc0);
      1:       return 32'(acc1);
      default: return 32'(acc2);
    endcase
  endfunction

  function automatic int model_sum(input int i, input logic [32:0] v);
    int s, w, n;
    logic [32:0] t;
    w = (i == 2) ? 4 : 8;
    n = (i == 2) ? 8 : 4;
    s = v[32] ? 1 : 0;
    for (int k = 0; k < n; k++) begin
      t = v >> (k * w);
      s += int'(t[7:0]) & ((1 << w) - 1);
    end
    return s;
  endfunction

  function automatic logic [32:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d, input logic cin);
    return {cin, d, c, b, a};
  endfunction

  function automatic bit idle();
    bit r;
    r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (ptr[i] != nb || tl[i] != hd[i]) r = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input int lane, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s lane%0d observed=%0d expected=%0d", tag, lane, obs, exp);
    end
  endtask

  task automatic start_list();
    nb = 0;
    for (int i = 0; i < 3; i++) ptr[i] = 0;
  endtask

  task automatic add_beat(input logic [32:0] v, input bit en, input bit first);
    b_ins[nb] = v;
    b_en[nb] = en;
    b_first[nb] = first;
    nb++;
  endtask

  task automatic check_lane(input int i);
    int cnt, h, lat, s;
    logic exp_rdy, exp_ov;
    lat = (i == 0) ? 1 : 2;
    cnt = tl[i] - hd[i];
    h = hd[i] % 64;
    exp_rdy = live && ((cnt < lat) || ordy[i]);
    exp_ov = (cnt > 0) && (cyc >= e_t[i][h] + lat);
    chk("in_ready", i, 32'(ir[i]), 32'(exp_rdy));
    chk("out_valid", i, 32'(ov[i]), 32'(exp_ov));
    if (exp_ov) begin
      chk("sm", i, obs_sm(i), 32'(e_sm[i][h]));
      chk("sm_zero", i, 32'(smz[i]), 32'(e_sm[i][h] == 0));
      chk("acc", i, obs_acc(i), 32'(e_acc[i][h]));
      chk("acc_sat", i, 32'(sat[i]), 32'(e_sat[i][h]));
      if (ordy[i]) hd[i]++;
    end
    if (iv[i] && exp_rdy) begin
      s = model_sum(i, ins_d[i]);
      if (aen[i]) begin
        if (afst[i]) begin
          macc[i] = s;
          msat[i] = 1'b0;
        end else if (macc[i] + s > 4095) begin
          macc[i] = 4095;
          msat[i] = 1'b1;
        end else begin
          macc[i] = macc[i] + s;
        end
      end
      e_sm[i][tl[i] % 64]  = s;
      e_acc[i][tl[i] % 64] = macc[i];
      e_sat[i][tl[i] % 64] = msat[i];
      e_t[i][tl[i] % 64]   = cyc;
      tl[i]++;
      ptr[i]++;
    end
  endtask

  // one clock cycle: drive from the list, check at the quiet point, advance past the edge
  task automatic tick();
    for (int i = 0; i < 3; i++) begin
      if (ptr[i] < nb) begin
        iv[i] = 1'b1;
        ins_d[i] = b_ins[ptr[i]];
        aen[i] = b_en[ptr[i]];
        afst[i] = b_first[ptr[i]];
      end else begin
        iv[i] = 1'b0;
        ins_d[i] = 33'd0;
        aen[i] = 1'b0;
        afst[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) check_lane(i);
    @(posedge clk);
    cyc++;
    live = (rst_n === 1'b1);
    @(negedge clk);
  endtask

  task automatic drain();
    int c;
    c = 0;
    ordy = 3'b111;
    while (c < 100 && !idle()) begin
      tick();
      c++;
    end
    chk("drain_done", 0, 32'(idle()), 32'd1);
  endtask

  task automatic reset_checks(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_out_valid"}, i, 32'(ov[i]), 32'd0);
      chk({tag, "_in_ready"}, i, 32'(ir[i]), 32'd0);
      chk({tag, "_sm"}, i, obs_sm(i), 32'd0);
      chk({tag, "_sm_zero"}, i, 32'(smz[i]), 32'd0);
      chk({tag, "_acc"}, i, obs_acc(i), 32'd0);
      chk({tag, "_acc_sat"}, i, 32'(sat[i]), 32'd0);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hd[i] = 0;
      tl[i] = 0;
      ptr[i] = 0;
      macc[i] = 0;
      msat[i] = 1'b0;
    end
    nb = 0;
    live = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    iv = 3'b000;
    ordy = 3'b111;
    aen = 3'b000;
    afst = 3'b000;
    for (int i = 0; i < 3; i++) ins_d[i] = 33'd0;
    nvec = 0;
    nerr = 0;
    cyc = 0;
    model_reset();
    #3;
    reset_checks("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // max operands with carry-in; first tick is the post-reset dead cycle
    start_list();
    add_beat(pack4(8'd255, 8'd255, 8'd255, 8'd255, 1'b1), 1'b0, 1'b0);
    tick();
    tick();
    chk("max_sm", 0, obs_sm(0), 32'd1021);
    chk("max_valid", 0, 32'(ov[0]), 32'd1);
    drain();

    // zero beat then 1+2+3+4 under three stalled cycles
    start_list();
    add_beat(pack4(8'd0, 8'd0, 8'd0, 8'd0, 1'b0), 1'b0, 1'b0);
    add_beat(pack4(8'd1, 8'd2, 8'd3, 8'd4, 1'b0), 1'b0, 1'b0);
    ordy = 3'b000;
    tick();
    tick();
    chk("stall_in_ready", 1, 32'(ir[1]), 32'd0);
    chk("stall_sm", 1, obs_sm(1), 32'd0);
    chk("stall_sm_zero", 1, 32'(smz[1]), 32'd1);
    tick();
    drain();

    // accumulate 100, 200, 300, then a non-accumulating 50 (its first bit is ignored)
    start_list();
    add_beat(pack4(8'd100, 8'd0, 8'd0, 8'd0, 1'b0), 1'b1, 1'b1);
    add_beat(pack4(8'd200, 8'd0, 8'd0, 8'd0, 1'b0), 1'b1, 1'b0);
    add_beat(pack4(8'd255, 8'd45, 8'd0, 8'd0, 1'b0), 1'b1, 1'b0);
    add_beat(pack4(8'd50, 8'd0, 8'd0, 8'd0, 1'b0), 1'b0, 1'b1);
    drain();
    chk("acc_600", 0, obs_acc(0), 32'd600);

    // saturation: five beats of 1021 clamp at 4095
    start_list();
    add_beat(pack4(8'd255, 8'd255, 8'd255, 8'd255, 1'b1), 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) add_beat(pack4(8'd255, 8'd255, 8'd255, 8'd255, 1'b1), 1'b1, 1'b0);
    drain();
    chk("sat_acc", 0, obs_acc(0), 32'd4095);
    chk("sat_flag", 0, 32'(sat[0]), 32'd1);
    start_list();
    add_beat(pack4(8'd5, 8'd0, 8'd0, 8'd0, 1'b0), 1'b1, 1'b1);
    drain();
    chk("restart_acc", 0, obs_acc(0), 32'd5);
    chk("restart_sat", 0, 32'(sat[0]), 32'd0);

    // 20 back-to-back random beats at full throughput
    start_list();
    for (int k = 0; k < 20; k++) begin
      add_beat({1'($urandom_range(1, 0)), 32'($urandom())}, 1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) == 0));
    end
    drain();

    // random beats under random back-pressure
    start_list();
    for (int k = 0; k < 30; k++) begin
      add_beat({1'($urandom_range(1, 0)), 32'($urandom())}, 1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) == 0));
    end
    for (int c = 0; c < 80; c++) begin
      ordy = 3'($urandom());
      tick();
    end
    drain();

    // reset with beats in flight, then a fresh beat
    start_list();
    for (int k = 0; k < 4; k++) add_beat(pack4(8'(k + 1), 8'd9, 8'd0, 8'd0, 1'b1), 1'b1, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_list();
    add_beat(pack4(8'd7, 8'd8, 8'd9, 8'd10, 1'b1), 1'b1, 1'b0);
    drain();
    chk("post_reset_acc", 0, obs_acc(0), 32'd35);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/adder_pipe_acc.md
Name: adder_pipe_acc

Overview:
- N-operand, W-bit parametrised adder with carry-in and a registered sum and zero flag.
- Adds a valid/ready handshake on input and output, a selectable pipeline latency of 1 or 2, and a saturating accumulator driven by per-beat sideband bits.
- Sits in the datapath as a drop-in successor to the fixed 4-operand registered adder; streaming producers and consumers connect directly.

Parameters:
- W, 8, operand width in bits.
- N, 4, number of operands; legal range 2..16.
- LAT, 1, pipeline latency in cycles; legal values 1 or 2.
- AW, 24, accumulator width; must be >= SW.
- SW (localparam), W+$clog2(N), sum width. Always holds N*(2^W-1)+1 without overflow.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- ins  in  N*W+1  packed operands: operand k at [k*W+W-1:k*W]; carry-in at bit N*W.
- in_acc_en  in  1  this beat updates the accumulator.
- in_acc_first  in  1  this beat restarts the accumulation (acc = sum).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sm  out  SW  registered sum.
- sm_zero  out  1  registered (sum == 0).
- acc  out  AW  accumulator value including this beat.
- acc_sat  out  1  sticky saturation flag of the current accumulation.

Behaviour:
- Reset: asynchronous assert on rst_n low. All valid bits, sm, sm_zero, acc and acc_sat are cleared to 0. In-flight beats are discarded with no partial output. in_ready goes to 1 on the first edge after deassert.
- Arithmetic: sm = sum of the N zero-extended operands + cin, computed at SW bits; no truncation is possible.
- LAT=1:
  - Combinational N-input sum feeds the output register.
  - A beat accepted on cycle t gives out_valid on t+1.
- LAT=2:
  - Stage 1 registers the pairwise partial sums: ceil(N/2) values of W+1 bits, cin, and the sideband bits.
  - Stage 2 reduces them to the output register.
  - Accept at t gives out_valid at t+2.
- Handshake:
  - Transfer happens when valid && ready.
  - A stage loads when it is empty or the stage after it transfers this cycle.
  - in_ready = stage-1 load condition. It may depend combinationally on out_ready.
  - Full throughput: one beat per cycle while out_ready=1.
  - While out_valid=1 && out_ready=0: sm, sm_zero, acc and acc_sat hold stable. No beat is lost or duplicated.
- Accumulator:
  - Evaluated only when a beat loads the output register. in_acc_en and in_acc_first travel with the beat.
  - acc_en=0: acc and acc_sat hold.
  - acc_en=1, first=1: acc = zero-extended sm; acc_sat = 0.
  - acc_en=1, first=0: acc = acc + sm.
  - If that addition exceeds 2^AW-1, acc = 2^AW-1 and acc_sat = 1.
  - acc_sat stays set until the next first=1 beat or reset.
  - acc_en=0 with first=1: first is ignored.
- Internal accumulator state updates at output-register load, not at output handshake. The acc value presented always includes the currently presented beat.
- Simultaneous output transfer and new load: the new beat replaces the old one in the same cycle, with no bubble.

Decomposition:
- Package adder_pipe_pkg:
  - function sum_width(W,N).
  - LAT legality check constant (elaboration error if LAT is not 1/2 or N < 2).
  - packed struct type for the sideband bits {acc_en, acc_first}.
- Sub-module pipe_reg:
  - One generic valid/ready pipeline register, with data width as a parameter.
  - Instantiated LAT times, with arithmetic between instances.
- Top-level holds the adder logic and the accumulator.

Test Plan (W=8, N=4, AW=12 unless stated):
1. Max inputs, LAT=1: operands 255,255,255,255, cin=1 -> sm=1021, sm_zero=0, out_valid exactly 1 cycle after accept.
2. Zero and back-pressure, LAT=2: beats 0s, then 1,2,3,4 cin=0, with out_ready=0 for 3 cycles -> first output sm=0, sm_zero=1, held stable. in_ready drops after 2 beats are buffered. The second output is sm=10. No loss or duplication.
3. Accumulate: beats sm=100 (first=1), 200, 300 (en=1) -> acc = 100, 300, 600. A beat with en=0 and sm=50 -> acc stays 600.
4. Saturation: first beat sm=1021, then 4 beats of 1021 -> acc = 1021, 2042, 3063, 4084, then 4095 with acc_sat=1. A next first=1 beat with sm=5 -> acc=5, acc_sat=0.
5. Throughput, LAT=2, N=8, W=4: 20 back-to-back random beats with out_ready=1 -> 20 outputs on consecutive cycles, matching the reference model.
6. Reset mid-stream: assert rst_n low while 2 beats are in flight -> out_valid, sm, acc and acc_sat are 0 immediately. After release, a new beat gives the correct sm with no stale output.
